// File: rtl/fx2_tag_packetizer_if.sv
// Tag-word handshake and FX2 slave-FIFO write-side bus bundle.
// The master drives tags and grant; the slave is the packetizer.
interface fx2_tag_packetizer_if #(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 16
);
  logic [8*WORD_BYTES-1:0]     TAG_DATA;
  logic                        TAG_VALID;
  logic                        TAG_READY;
  logic                        FIFO4_ready_to_accept_data;
  logic                        BUS_GNT;
  logic                        BUS_REQ;
  logic [1:0]                  FIFO_FIFOADR;
  logic [7:0]                  FIFO_DATAOUT;
  logic                        FIFO_DATAOUT_OE;
  logic                        FIFO_WR;
  logic                        FIFO_PKTEND;
  logic [$clog2(FIFO_DEPTH):0] FILL_LEVEL;

  modport master (
    output TAG_DATA, TAG_VALID,
    output FIFO4_ready_to_accept_data, BUS_GNT,
    input  TAG_READY, BUS_REQ, FIFO_FIFOADR,
    input  FIFO_DATAOUT, FIFO_DATAOUT_OE,
    input  FIFO_WR, FIFO_PKTEND, FILL_LEVEL
  );

  modport slave (
    input  TAG_DATA, TAG_VALID,
    input  FIFO4_ready_to_accept_data, BUS_GNT,
    output TAG_READY, BUS_REQ, FIFO_FIFOADR,
    output FIFO_DATAOUT, FIFO_DATAOUT_OE,
    output FIFO_WR, FIFO_PKTEND, FILL_LEVEL
  );
endinterface

// File: rtl/fx2_tag_packetizer.sv
// Buffers time-tag words and serializes them LSB-byte-first into
// FX2 FIFO4, committing short packets with PKTEND after idle time.
module fx2_tag_packetizer #(
  parameter int         WORD_BYTES    = 4,
  parameter int         FIFO_DEPTH    = 16,
  parameter int         PKT_BYTES     = 512,
  parameter int         FLUSH_TIMEOUT = 65535,
  parameter logic [1:0] TX_FIFOADR    = 2'b10
) (
  input logic                 FIFO_CLK,
  input logic                 RST_n,
  fx2_tag_packetizer_if.slave bus
);
  localparam int DW  = 8*WORD_BYTES;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BCW = $clog2(PKT_BYTES);
  localparam int TW  = $clog2(FLUSH_TIMEOUT+1);
  localparam int IW  = (WORD_BYTES > 1) ?
                       $clog2(WORD_BYTES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_TURN, S_WRITE, S_FLUSH, S_REL
  } state_t;

  state_t          state, state_nx;
  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [AW:0]     count;
  logic            rdy_q;
  logic [DW-1:0]   sh_data;
  logic [IW-1:0]   sh_idx;
  logic            sh_valid;
  logic [BCW-1:0]  byte_cnt;
  logic [TW-1:0]   timer;

  logic full, empty, push, pop, gnt;
  logic wr, last_wr, pktend, oe, req;
  logic flush_pend;

  assign gnt     = bus.BUS_GNT;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push    = bus.TAG_VALID && rdy_q && !full;
  assign last_wr = wr && (sh_idx == IW'(WORD_BYTES-1));
  // Words leave the buffer only once the bus is ours.
  assign pop     = !empty && (!sh_valid || last_wr) &&
                   (state == S_TURN || state == S_WRITE);
  assign flush_pend = (timer == TW'(FLUSH_TIMEOUT)) &&
                      (byte_cnt != '0);

  always_ff @(posedge FIFO_CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (push) begin
        mem[wptr] <= bus.TAG_DATA;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge FIFO_CLK or negedge RST_n) begin
    if (!RST_n) begin
      sh_data  <= '0;
      sh_idx   <= '0;
      sh_valid <= 1'b0;
    end else if (pop) begin
      sh_data  <= mem[rptr];
      sh_idx   <= '0;
      sh_valid <= 1'b1;
    end else if (last_wr) begin
      sh_valid <= 1'b0;
    end else if (wr) begin
      sh_data  <= sh_data >> 8;
      sh_idx   <= sh_idx + 1'b1;
    end
  end

  always_ff @(posedge FIFO_CLK or negedge RST_n) begin
    if (!RST_n) begin
      byte_cnt <= '0;
      timer    <= '0;
    end else begin
      if (pktend)
        byte_cnt <= '0;
      else if (wr)
        byte_cnt <= (byte_cnt == BCW'(PKT_BYTES-1)) ?
                    '0 : byte_cnt + 1'b1;
      if (push || wr || pktend || byte_cnt == '0)
        timer <= '0;
      else if (empty && !sh_valid &&
               timer != TW'(FLUSH_TIMEOUT))
        timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge FIFO_CLK or negedge RST_n) begin
    if (!RST_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    req      = 1'b0;
    oe       = 1'b0;
    wr       = 1'b0;
    pktend   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty || sh_valid || flush_pend)
          state_nx = S_REQ;
      end
      S_REQ: begin
        req = 1'b1;
        if (gnt) state_nx = S_TURN;
      end
      S_TURN: begin
        req = 1'b1;
        oe  = 1'b1;
        if (!gnt)           state_nx = S_REQ;
        else if (flush_pend) state_nx = S_FLUSH;
        else                state_nx = S_WRITE;
      end
      S_WRITE: begin
        req = 1'b1;
        oe  = 1'b1;
        wr  = gnt && bus.FIFO4_ready_to_accept_data &&
              sh_valid;
        if (!gnt)
          state_nx = S_REQ;
        else if ((!sh_valid || last_wr) && empty)
          state_nx = S_REL;
      end
      S_FLUSH: begin
        req    = 1'b1;
        oe     = 1'b1;
        pktend = gnt;
        state_nx = gnt ? S_REL : S_REQ;
      end
      S_REL:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.TAG_READY       = rdy_q && !full;
  assign bus.BUS_REQ         = req;
  assign bus.FIFO_FIFOADR    = TX_FIFOADR;
  assign bus.FIFO_DATAOUT    = oe ? sh_data[7:0] : 8'h00;
  assign bus.FIFO_DATAOUT_OE = oe;
  assign bus.FIFO_WR         = wr;
  assign bus.FIFO_PKTEND     = pktend;
  assign bus.FILL_LEVEL      = count;
endmodule

// File: tb/tb_fx2_tag_packetizer.sv
// Scoreboard bench for fx2_tag_packetizer: expected bytes queued on
// accepted pushes, checked by a monitor on every FIFO_WR.
module tb_fx2_tag_packetizer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fx2_tag_packetizer_if #(.WORD_BYTES(4), .FIFO_DEPTH(16)) b ();

  fx2_tag_packetizer #(
    .WORD_BYTES(4), .FIFO_DEPTH(16), .PKT_BYTES(512),
    .FLUSH_TIMEOUT(16), .TX_FIFOADR(2'b10)
  ) dut (
    .FIFO_CLK(clk),
    .RST_n(rst_n),
    .bus(b)
  );

  logic [7:0] exp_q [$];
  int         wr_log [$];
  int         pkt_cnt = 0;
  int         pkt_cyc = 0;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic monitor_loop();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (b.FIFO_WR) begin
          wr_log.push_back(cyc);
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_wr", b.FIFO_DATAOUT, 0);
          end else begin
            e = exp_q.pop_front();
            chk(b.FIFO_DATAOUT === e, "wr_byte",
                b.FIFO_DATAOUT, e);
          end
        end
        if (b.FIFO_PKTEND) begin
          pkt_cnt++;
          pkt_cyc = cyc;
        end
      end
    end
  endtask

  task automatic push_word(input logic [31:0] w, output int acc);
    bit done = 1'b0;
    acc = -1;
    b.TAG_DATA  = w;
    b.TAG_VALID = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (b.TAG_READY) begin
        acc = cyc;
        for (int k = 0; k < 4; k++) exp_q.push_back(w[8*k +: 8]);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    b.TAG_VALID = 1'b0;
    if (!done) chk(1'b0, "push_timeout", 0, 1);
  endtask

  task automatic wait_wr(input int target, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      if (wr_log.size() >= target) done = 1'b1;
    end
    if (!done) chk(1'b0, "wr_timeout", wr_log.size(), target);
    #1;
  endtask

  task automatic wait_pkt(input int target, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      if (pkt_cnt >= target) done = 1'b1;
    end
    chk(done, "pktend_wait", pkt_cnt, target);
    #1;
  endtask

  function automatic logic [31:0] seq_word(input int i);
    logic [7:0] b0;
    b0 = 8'(4*i);
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  initial begin
    int n, g, pk0;
    fork monitor_loop(); join_none
    b.TAG_DATA = '0;
    b.TAG_VALID = 1'b0;
    b.FIFO4_ready_to_accept_data = 1'b1;
    b.BUS_GNT = 1'b1;

    repeat (3) @(negedge clk);
    chk({b.FIFO_WR, b.FIFO_DATAOUT_OE, b.BUS_REQ,
         b.FIFO_PKTEND, b.TAG_READY} == 5'b0, "rst_ctl",
        {b.FIFO_WR, b.FIFO_DATAOUT_OE, b.BUS_REQ,
         b.FIFO_PKTEND, b.TAG_READY}, 0);
    chk(b.FILL_LEVEL == 0, "rst_fill", b.FILL_LEVEL, 0);
    chk(b.FIFO_FIFOADR == 2'b10, "rst_adr", b.FIFO_FIFOADR, 2);
    chk(b.FIFO_DATAOUT == 0, "rst_data", b.FIFO_DATAOUT, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk(b.TAG_READY == 1'b1, "ready_after_rst", b.TAG_READY, 1);
    @(posedge clk); #1;

    wr_log.delete();
    push_word(32'hDDCCBBAA, n);
    wait_wr(4, 40);
    if (wr_log.size() >= 4) begin
      chk(wr_log[0] == n + 4, "t1_latency", wr_log[0] - n, 4);
      chk(wr_log[3] == n + 7, "t1_last", wr_log[3] - n, 7);
    end
    wait_pkt(1, 60);
    if (wr_log.size() >= 4)
      chk(pkt_cyc == wr_log[3] + 20, "t1_pkt_cyc",
          pkt_cyc - wr_log[3], 20);
    @(negedge clk);
    chk(!b.BUS_REQ && !b.FIFO_DATAOUT_OE, "t1_release",
        {b.BUS_REQ, b.FIFO_DATAOUT_OE}, 0);
    @(posedge clk); #1;

    wr_log.delete();
    pk0 = pkt_cnt;
    for (int i = 0; i < 128; i++) push_word(seq_word(i), n);
    wait_wr(512, 800);
    if (wr_log.size() >= 512)
      chk(wr_log[511] - wr_log[0] == 511, "t2_contig",
          wr_log[511] - wr_log[0], 511);
    repeat (40) @(posedge clk);
    #1;
    chk(wr_log.size() == 512, "t2_count", wr_log.size(), 512);
    chk(pkt_cnt == pk0, "t2_no_pktend", pkt_cnt, pk0);
    chk(exp_q.size() == 0, "t2_drained", exp_q.size(), 0);

    wr_log.delete();
    pk0 = pkt_cnt;
    push_word(32'hDDCCBBAA, n);
    wait_wr(2, 40);
    b.FIFO4_ready_to_accept_data = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk(b.FIFO_WR == 1'b0, "t3_stall_wr", b.FIFO_WR, 0);
      chk(b.FIFO_DATAOUT == 8'hCC, "t3_hold", b.FIFO_DATAOUT, 8'hCC);
      @(posedge clk);
    end
    #1 b.FIFO4_ready_to_accept_data = 1'b1;
    wait_wr(4, 20);
    if (wr_log.size() >= 4)
      chk(wr_log[2] - wr_log[1] == 4, "t3_gap",
          wr_log[2] - wr_log[1], 4);
    wait_pkt(pk0 + 1, 60);

    wr_log.delete();
    pk0 = pkt_cnt;
    b.BUS_GNT = 1'b0;
    for (int i = 0; i < 16; i++) push_word(seq_word(i + 7), n);
    b.TAG_DATA  = 32'h12345678;
    b.TAG_VALID = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk(b.TAG_READY == 1'b0, "t4_full", b.TAG_READY, 0);
      @(posedge clk); #1;
    end
    b.TAG_VALID = 1'b0;
    @(negedge clk);
    chk(b.FILL_LEVEL == 16, "t4_fill", b.FILL_LEVEL, 16);
    chk(b.BUS_REQ && !b.FIFO_DATAOUT_OE, "t4_req",
        {b.BUS_REQ, b.FIFO_DATAOUT_OE}, 2);
    @(posedge clk); #1;
    g = cyc;
    b.BUS_GNT = 1'b1;
    wait_wr(64, 200);
    if (wr_log.size() >= 64) begin
      chk(wr_log[0] == g + 2, "t4_turn", wr_log[0] - g, 2);
      chk(wr_log[63] - wr_log[0] == 63, "t4_contig",
          wr_log[63] - wr_log[0], 63);
    end
    chk(exp_q.size() == 0, "t4_drained", exp_q.size(), 0);
    wait_pkt(pk0 + 1, 80);

    wr_log.delete();
    pk0 = pkt_cnt;
    push_word(32'h88776655, n);
    wait_wr(2, 40);
    b.BUS_GNT = 1'b0;
    @(negedge clk);
    chk(b.FIFO_WR == 1'b0, "t5_wr_gated", b.FIFO_WR, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk(b.BUS_REQ && !b.FIFO_DATAOUT_OE, "t5_req",
        {b.BUS_REQ, b.FIFO_DATAOUT_OE}, 2);
    @(posedge clk); #1 b.BUS_GNT = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk(b.FIFO_DATAOUT_OE && !b.FIFO_WR, "t5_turn",
        {b.FIFO_DATAOUT_OE, b.FIFO_WR}, 2);
    wait_wr(4, 20);
    if (wr_log.size() >= 4)
      chk(wr_log[2] - wr_log[1] == 5, "t5_gap",
          wr_log[2] - wr_log[1], 5);
    wait_pkt(pk0 + 1, 60);

    wr_log.delete();
    for (int i = 0; i < 3; i++) push_word(seq_word(i + 40), n);
    wait_wr(2, 40);
    #2 rst_n = 1'b0;
    #1;
    chk({b.FIFO_WR, b.FIFO_DATAOUT_OE, b.BUS_REQ,
         b.FIFO_PKTEND, b.TAG_READY} == 5'b0, "t6_rst_ctl",
        {b.FIFO_WR, b.FIFO_DATAOUT_OE, b.BUS_REQ,
         b.FIFO_PKTEND, b.TAG_READY}, 0);
    chk(b.FILL_LEVEL == 0, "t6_rst_fill", b.FILL_LEVEL, 0);
    chk(b.FIFO_DATAOUT == 0, "t6_rst_data", b.FIFO_DATAOUT, 0);
    exp_q.delete();
    pk0 = pkt_cnt;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk(b.FILL_LEVEL == 0 && b.TAG_READY, "t6_after",
        {b.FILL_LEVEL, b.TAG_READY}, 1);
    repeat (40) @(posedge clk);
    #1;
    chk(pkt_cnt == pk0, "t6_no_pktend", pkt_cnt, pk0);
    chk(wr_log.size() == 2, "t6_no_wr", wr_log.size(), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
